// File: rtl/mips_timer_pkg.sv
// Shared constants for the mips_timer block: register map, CTRL layout, MODE codes and FSM states.
// Both the bus bridge and the testbench import this package.
package mips_timer_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_W        = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // MODE 1x is deliberately folded onto one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/mips_timer_if.sv
// Bus-side signals between the system bus bridge and the timer.
interface mips_timer_if;
    import mips_timer_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BUS_W-1:0]  din;
    logic [BUS_W-1:0]  dout;
    logic              irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);

endinterface

// File: rtl/mips_timer.sv
// Memory-mapped down-counter timer with one-shot (level irq) and auto-reload (pulse irq) modes.
// Drives one HWInt line; registers CTRL/PRESET/COUNT sit at word offsets 0/1/2.
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic         clk,
    input logic         reset,
    mips_timer_if.slave bus
);

    logic [1:0]       r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irq_flag;

    logic [1:0]       w_state_nxt;
    ctrl_t            w_ctrl_nxt;
    ctrl_t            w_ctrl_wdata;
    logic [CNT_W-1:0] w_preset_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_irq_flag_nxt;
    logic             w_flag_set;
    logic             w_flag_fsm_clr;
    logic             w_flag_ack;
    logic             w_en_clr;
    logic             w_ctrl_wr;
    logic             w_preset_wr;

    assign w_ctrl_wr    = bus.we && (bus.addr == ADDR_CTRL);
    assign w_preset_wr  = bus.we && (bus.addr == ADDR_PRESET);
    assign w_ctrl_wdata = ctrl_t'(bus.din[CTRL_W-1:0]);

    // A CTRL write acknowledges only an irq that is visible and stays unmasked, so
    // toggling IM off and back on re-exposes a pending one-shot interrupt.
    assign w_flag_ack = w_ctrl_wr && r_ctrl.im && w_ctrl_wdata.im;

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_flag_set     = 1'b0;
        w_flag_fsm_clr = 1'b0;
        w_en_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ctrl.en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl.en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    // Covers COUNT of 1 and 0, so PRESET=0 times out like PRESET=1.
                    w_count_nxt = '0;
                    w_flag_set  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                w_state_nxt = ST_IDLE;
                if (is_reload(r_ctrl.mode)) begin
                    w_flag_fsm_clr = 1'b1;
                end else begin
                    w_en_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_en_clr) begin
            w_ctrl_nxt.en = 1'b0;
        end
        if (w_ctrl_wr) begin
            w_ctrl_nxt = w_ctrl_wdata;
        end
    end

    assign w_preset_nxt = w_preset_wr ? bus.din[CNT_W-1:0] : r_preset;

    // Set beats any clear on the same edge so no interrupt is lost.
    always_comb begin
        w_irq_flag_nxt = r_irq_flag;
        if (w_flag_set) begin
            w_irq_flag_nxt = 1'b1;
        end else if (w_flag_ack || w_flag_fsm_clr) begin
            w_irq_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_irq_flag_nxt;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            ADDR_CTRL:   bus.dout = {{(BUS_W - CTRL_W){1'b0}}, r_ctrl};
            ADDR_PRESET: bus.dout = BUS_W'(r_preset);
            ADDR_COUNT:  bus.dout = BUS_W'(r_count);
            default:     bus.dout = '0;
        endcase
    end

    assign bus.irq = r_irq_flag & r_ctrl.im;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: a run-position model checked every cycle plus literal spot checks.
module tb_mips_timer;
    import mips_timer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mips_timer_if ifc();

    mips_timer #(.CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a run is tracked by its position m_run (edges since leaving idle).
    // 1 = about to load, 2..len+1 = counting, len+2 = interrupt edge pending.
    logic        m_en    = 1'b0;
    logic        m_im    = 1'b0;
    logic [1:0]  m_mode  = 2'b00;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count  = '0;
    logic        m_flag  = 1'b0;
    int          m_run   = 0;
    int          m_len   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_en <= 1'b0; m_im <= 1'b0; m_mode <= 2'b00;
            m_preset <= '0; m_count <= '0; m_flag <= 1'b0;
            m_run <= 0; m_len <= 0;
        end else begin : model_step
            logic        n_en, n_im, setf, clrf;
            logic [1:0]  n_mode;
            logic [31:0] n_preset, n_count;
            int          n_run, n_len;
            n_en = m_en; n_im = m_im; n_mode = m_mode;
            n_preset = m_preset; n_count = m_count;
            n_run = m_run; n_len = m_len;
            setf = 1'b0; clrf = 1'b0;
            if (m_run == 0) begin
                if (m_en) n_run = 1;
            end else if (m_run == 1) begin
                n_count = m_preset;
                n_len   = (m_preset == 0) ? 1 : int'(m_preset);
                n_run   = 2;
            end else if (m_run <= m_len + 1) begin
                if (!m_en) begin
                    n_run = 0;
                end else begin
                    n_run = m_run + 1;
                    if (n_run == m_len + 2) begin
                        n_count = 0;
                        setf    = 1'b1;
                    end else begin
                        n_count = 32'(m_len - (n_run - 2));
                    end
                end
            end else begin
                n_run = 0;
                if (m_mode == MODE_RELOAD) clrf = 1'b1;
                else n_en = 1'b0;
            end
            if (ifc.we && ifc.addr == ADDR_CTRL) begin
                {n_im, n_mode, n_en} = ifc.din[3:0];
                if (m_im && ifc.din[3]) clrf = 1'b1;
            end
            if (ifc.we && ifc.addr == ADDR_PRESET) n_preset = ifc.din;
            m_en <= n_en; m_im <= n_im; m_mode <= n_mode;
            m_preset <= n_preset; m_count <= n_count;
            m_flag <= setf ? 1'b1 : (clrf ? 1'b0 : m_flag);
            m_run <= n_run; m_len <= n_len;
        end
    end

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        case (a)
            ADDR_CTRL:   return {28'b0, m_im, m_mode, m_en};
            ADDR_PRESET: return m_preset;
            ADDR_COUNT:  return m_count;
            default:     return 32'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("cyc_dout", ifc.dout, exp_dout(ifc.addr));
        check("cyc_irq", {31'b0, ifc.irq}, {31'b0, m_flag & m_im});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ifc.addr = a; ifc.we = 1'b1; ifc.din = d;
        tick(1);
        ifc.we = 1'b0; ifc.din = '0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        ifc.addr = a;
        #1;
        check(name, ifc.dout, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {31'b0, ifc.irq}, {31'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        ifc.addr = ADDR_CTRL; ifc.we = 1'b0; ifc.din = '0;
        #1 reset = 1'b0;
        tick(2);
        for (int a = 0; a < 4; a++) rd("rst_dout", 2'(a), 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;
        tick(1);
        rd("rst_nocount", ADDR_COUNT, 32'h0);

        // One-shot, PRESET=5: COUNT 5..1 then irq on edge 7, held until acknowledged.
        wr(ADDR_PRESET, 5);
        wr(ADDR_CTRL, 32'h9);
        tick(2);
        rd("os_count_e2", ADDR_COUNT, 5);
        check("model_count_e2", m_count, 5);
        for (int k = 4; k >= 1; k--) begin
            tick(1);
            rd("os_count", ADDR_COUNT, 32'(k));
            chk_irq("os_irq_low", 1'b0);
        end
        tick(1);
        rd("os_count_e7", ADDR_COUNT, 0);
        chk_irq("os_irq_e7", 1'b1);
        check("model_irq_e7", {31'b0, m_flag & m_im}, 32'h1);
        tick(1);
        rd("os_ctrl_en_clr", ADDR_CTRL, 32'h8);
        tick(3);
        chk_irq("os_irq_held", 1'b1);
        wr(ADDR_CTRL, 32'h8);
        chk_irq("os_ack", 1'b0);

        // Auto-reload, PRESET=3: one-cycle pulse every 6 cycles, first at edge 5.
        wr(ADDR_PRESET, 3);
        wr(ADDR_CTRL, 32'hB);
        pulses = 0;
        for (int e = 1; e <= 24; e++) begin
            tick(1);
            chk_irq("ar_irq", (e >= 5) && ((e - 5) % 6 == 0));
            if (ifc.irq) pulses++;
        end
        check("ar_pulses", 32'(pulses), 4);
        rd("ar_ctrl", ADDR_CTRL, 32'hB);
        wr(ADDR_CTRL, 32'h0);
        tick(4);

        // Masked: flag sets silently; unmasking exposes it; a second write acknowledges.
        wr(ADDR_PRESET, 2);
        wr(ADDR_CTRL, 32'h1);
        tick(4);
        chk_irq("mask_irq_low", 1'b0);
        check("model_flag_masked", {31'b0, m_flag}, 32'h1);
        tick(1);
        rd("mask_ctrl", ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h8);
        chk_irq("mask_unmask", 1'b1);
        wr(ADDR_CTRL, 32'h8);
        chk_irq("mask_ack", 1'b0);

        // MODE=10 behaves as one-shot.
        wr(ADDR_PRESET, 1);
        wr(ADDR_CTRL, 32'hD);
        tick(3);
        chk_irq("m10_irq", 1'b1);
        tick(1);
        rd("m10_ctrl", ADDR_CTRL, 32'hC);
        wr(ADDR_CTRL, 32'h8);

        // Pause at 6, ignored COUNT writes, re-enable reloads from PRESET.
        wr(ADDR_PRESET, 10);
        wr(ADDR_CTRL, 32'h9);
        tick(5);
        rd("pause_count7", ADDR_COUNT, 7);
        wr(ADDR_CTRL, 32'h8);
        rd("pause_count6", ADDR_COUNT, 6);
        tick(4);
        rd("pause_frozen", ADDR_COUNT, 6);
        wr(ADDR_COUNT, 32'h55);
        rd("pause_cnt_wr", ADDR_COUNT, 6);
        wr(ADDR_CTRL, 32'h9);
        tick(1);
        rd("resume_load", ADDR_COUNT, 6);
        tick(1);
        rd("resume_reload", ADDR_COUNT, 10);
        wr(ADDR_COUNT, 32'h77);
        rd("resume_cnt_wr", ADDR_COUNT, 9);
        wr(ADDR_CTRL, 32'h8);
        tick(3);

        // CTRL write on the 1->0 edge: set wins over acknowledge.
        wr(ADDR_PRESET, 3);
        wr(ADDR_CTRL, 32'h9);
        tick(4);
        rd("race_count1", ADDR_COUNT, 1);
        wr(ADDR_CTRL, 32'h9);
        chk_irq("race_set_wins", 1'b1);
        tick(2);
        chk_irq("race_held", 1'b1);
        rd("race_ctrl", ADDR_CTRL, 32'h8);
        wr(ADDR_CTRL, 32'h8);

        // PRESET write mid-count affects only the next reload.
        wr(ADDR_PRESET, 4);
        wr(ADDR_CTRL, 32'hB);
        tick(2);
        rd("pre_count4", ADDR_COUNT, 4);
        wr(ADDR_PRESET, 2);
        rd("pre_count3", ADDR_COUNT, 3);
        tick(3);
        chk_irq("pre_irq", 1'b1);
        tick(3);
        rd("pre_reload2", ADDR_COUNT, 2);
        wr(ADDR_CTRL, 32'h0);
        tick(4);

        // Reset with an irq pending, then reset mid-count.
        wr(ADDR_PRESET, 1);
        wr(ADDR_CTRL, 32'h9);
        tick(3);
        chk_irq("rst2_pending", 1'b1);
        reset = 1'b0;
        #1;
        chk_irq("rst2_irq_now", 1'b0);
        tick(1);
        reset = 1'b1;
        wr(ADDR_PRESET, 20);
        wr(ADDR_CTRL, 32'h9);
        tick(5);
        rd("rst3_count17", ADDR_COUNT, 17);
        reset = 1'b0;
        rd("rst3_count0", ADDR_COUNT, 0);
        rd("rst3_ctrl0", ADDR_CTRL, 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        rd("rst3_halted", ADDR_COUNT, 0);
        rd("rst3_preset0", ADDR_PRESET, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
